// File: rtl/raptor64_pkg.sv
// Shared encodings for the raptor64 add/subtract unit: op_i codes and sequencer states.
package raptor64_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_ADDU    = 3'd1,
        OP_SUB     = 3'd2,
        OP_SUBU    = 3'd3,
        OP_BCD_ADD = 3'd4,
        OP_BCD_SUB = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BIN,
        ST_BCD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/raptor64_bcd_digit.sv
// One BCD digit adder with ripple carry; sub selects the nines' complement of b.
module raptor64_bcd_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] bEff;
    logic [4:0] raw;
    logic [4:0] adj;

    // Digits above 9 are not flagged; they simply go through the same +6 correction.
    always_comb begin
        bEff = sub ? (4'd9 - b) : b;
        raw  = {1'b0, a} + {1'b0, bEff} + {4'd0, cin};
        adj  = (raw > 5'd9) ? (raw + 5'd6) : raw;
        s    = adj[3:0];
        cout = (raw > 5'd9);
    end

endmodule

// File: rtl/raptor64_addsub_seq.sv
// Sequential binary/BCD add-subtract unit. Define RAPTOR64_BCD_EN to build the
// multi-cycle BCD path; otherwise BCD ops are handled as invalid ops.
module raptor64_addsub_seq
    import raptor64_pkg::*;
#(
    parameter int WID = 64,
    parameter int DPC = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [2:0]     op_i,
    input  logic [WID-1:0] a_i,
    input  logic [WID-1:0] b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [WID-1:0] o_o,
    output logic           c_o,
    output logic           ov_o
);

    if (WID % (4 * DPC) != 0) begin : gBadWid
        $error("raptor64_addsub_seq: WID must be a multiple of 4*DPC");
    end

    state_e         state;
    logic [2:0]     opReg;
    logic [WID-1:0] aReg;
    logic [WID-1:0] bReg;

    logic           isSub;
    logic           isValid;
    logic           signedOp;
    logic [WID-1:0] bOp;
    logic [WID:0]   sum;
    logic           cBin;
    logic           ovBin;

    // Single WID+1 adder: subtraction is a + ~b + 1, borrow is the inverted carry.
    always_comb begin
        isSub    = (opReg == OP_SUB) || (opReg == OP_SUBU);
        isValid  = (opReg <= OP_SUBU);
        signedOp = (opReg == OP_ADD) || (opReg == OP_SUB);
        bOp      = isSub ? ~bReg : bReg;
        sum      = {1'b0, aReg} + {1'b0, bOp} + {{WID{1'b0}}, isSub};
        cBin     = isSub ? ~sum[WID] : sum[WID];
        ovBin    = signedOp && (aReg[WID-1] == bOp[WID-1]) && (sum[WID-1] != aReg[WID-1]);
    end

`ifdef RAPTOR64_BCD_EN
    localparam int GW = 4 * DPC;
    localparam int N  = WID / GW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] digCnt;
    logic          bcdCarry;
    logic          bcdSub;
    logic [DPC:0]  chain;
    logic [GW-1:0] grpSum;

    assign bcdSub   = (opReg == OP_BCD_SUB);
    assign chain[0] = bcdCarry;

    for (genvar d = 0; d < DPC; d++) begin : gDig
        raptor64_bcd_digit uDig (
            .a    (aReg[4*d +: 4]),
            .b    (bReg[4*d +: 4]),
            .sub  (bcdSub),
            .cin  (chain[d]),
            .s    (grpSum[4*d +: 4]),
            .cout (chain[d+1])
        );
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            opReg  <= '0;
            aReg   <= '0;
            bReg   <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            o_o    <= '0;
            c_o    <= 1'b0;
            ov_o   <= 1'b0;
`ifdef RAPTOR64_BCD_EN
            digCnt   <= '0;
            bcdCarry <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                    if (start_i) begin
                        opReg  <= op_i;
                        aReg   <= a_i;
                        bReg   <= b_i;
                        busy_o <= 1'b1;
                        state  <= ST_BIN;
`ifdef RAPTOR64_BCD_EN
                        if (op_i == OP_BCD_ADD || op_i == OP_BCD_SUB) begin
                            state    <= ST_BCD;
                            digCnt   <= '0;
                            bcdCarry <= (op_i == OP_BCD_SUB);
                        end
`endif
                    end
                end
                ST_BIN: begin
                    o_o    <= isValid ? sum[WID-1:0] : '0;
                    c_o    <= isValid && cBin;
                    ov_o   <= ovBin;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    state  <= ST_DONE;
                end
`ifdef RAPTOR64_BCD_EN
                ST_BCD: begin
                    // Operands shift down and result groups enter from the top, LSB group first.
                    aReg     <= aReg >> GW;
                    bReg     <= bReg >> GW;
                    o_o      <= (o_o >> GW) | (WID'(grpSum) << (WID - GW));
                    bcdCarry <= chain[DPC];
                    digCnt   <= digCnt + 1'b1;
                    if (digCnt == CW'(N - 1)) begin
                        c_o    <= bcdSub ? ~chain[DPC] : chain[DPC];
                        ov_o   <= 1'b0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raptor64_addsub_seq.sv
// Directed bench for raptor64_addsub_seq; BCD scenarios follow RAPTOR64_BCD_EN.
module tb_raptor64_addsub_seq;
    import raptor64_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] o_o;
    logic        c_o;
    logic        ov_o;

    int nChecks = 0;
    int nFails  = 0;

    raptor64_addsub_seq #(.WID(64), .DPC(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .o_o     (o_o),
        .c_o     (c_o),
        .ov_o    (ov_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Pulses start for one edge, scrambles operands afterwards, and returns the edge count to done_o.
    task automatic runOp(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, output int lat);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        tick();
        start_i = 1'b0; a_i = ~a; b_i = ~b; op_i = 3'd7;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_o) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0;
        tick(); tick();
        nChecks++; if (busy_o !== 1'b0) begin nFails++; $display("FAIL reset_busy got %b want 0", busy_o); end
        nChecks++; if (done_o !== 1'b0) begin nFails++; $display("FAIL reset_done got %b want 0", done_o); end
        nChecks++; if (o_o !== 64'h0) begin nFails++; $display("FAIL reset_o got %h want 0", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b00) begin nFails++; $display("FAIL reset_c_ov got %b want 00", {c_o, ov_o}); end
        rst_ni = 1'b1;
        tick();
        nChecks++; if (busy_o !== 1'b0) begin nFails++; $display("FAIL idle_busy got %b want 0", busy_o); end
    endtask

    task automatic test_add_overflow();
        int lat;
        start_i = 1'b1; op_i = OP_ADD; a_i = 64'h7FFF_FFFF_FFFF_FFFF; b_i = 64'h1;
        tick();
        start_i = 1'b0; a_i = '0; b_i = '0;
        nChecks++; if (busy_o !== 1'b1) begin nFails++; $display("FAIL add_busy got %b want 1", busy_o); end
        tick();
        lat = done_o ? 1 : -1;
        nChecks++; if (lat !== 1) begin nFails++; $display("FAIL add_latency got %0d want 1", lat); end
        nChecks++; if (o_o !== 64'h8000_0000_0000_0000) begin nFails++; $display("FAIL add_o got %h want 8000000000000000", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b01) begin nFails++; $display("FAIL add_c_ov got %b want 01", {c_o, ov_o}); end
        nChecks++; if (busy_o !== 1'b0) begin nFails++; $display("FAIL add_done_busy got %b want 0", busy_o); end
        tick();
        nChecks++; if (done_o !== 1'b0) begin nFails++; $display("FAIL done_pulse got %b want 0", done_o); end
        tick(); tick();
        nChecks++; if (o_o !== 64'h8000_0000_0000_0000) begin nFails++; $display("FAIL o_hold got %h want 8000000000000000", o_o); end
    endtask

    task automatic test_binary();
        int lat;
        runOp(OP_SUBU, 64'h0, 64'h1, lat);
        nChecks++; if (lat !== 1) begin nFails++; $display("FAIL subu_latency got %0d want 1", lat); end
        nChecks++; if (o_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin nFails++; $display("FAIL subu_o got %h want ffffffffffffffff", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b10) begin nFails++; $display("FAIL subu_c_ov got %b want 10", {c_o, ov_o}); end
        runOp(OP_ADDU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat);
        nChecks++; if (o_o !== 64'h0) begin nFails++; $display("FAIL addu_o got %h want 0", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b10) begin nFails++; $display("FAIL addu_c_ov got %b want 10", {c_o, ov_o}); end
        runOp(OP_SUB, 64'h8000_0000_0000_0000, 64'h1, lat);
        nChecks++; if (o_o !== 64'h7FFF_FFFF_FFFF_FFFF) begin nFails++; $display("FAIL sub_ovf_o got %h want 7fffffffffffffff", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b01) begin nFails++; $display("FAIL sub_ovf_c_ov got %b want 01", {c_o, ov_o}); end
        runOp(OP_SUB, 64'd5, 64'd7, lat);
        nChecks++; if (o_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin nFails++; $display("FAIL sub_neg_o got %h want fffffffffffffffe", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b10) begin nFails++; $display("FAIL sub_neg_c_ov got %b want 10", {c_o, ov_o}); end
        runOp(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        nChecks++; if (o_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin nFails++; $display("FAIL add_neg_o got %h want fffffffffffffffe", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b10) begin nFails++; $display("FAIL add_neg_c_ov got %b want 10", {c_o, ov_o}); end
        runOp(OP_ADDU, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, lat);
        nChecks++; if ({c_o, ov_o} !== 2'b00) begin nFails++; $display("FAIL addu_noov got %b want 00", {c_o, ov_o}); end
        runOp(3'd7, 64'h1234, 64'h5678, lat);
        nChecks++; if (lat !== 1) begin nFails++; $display("FAIL inv_latency got %0d want 1", lat); end
        nChecks++; if (o_o !== 64'h0) begin nFails++; $display("FAIL inv_o got %h want 0", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b00) begin nFails++; $display("FAIL inv_c_ov got %b want 00", {c_o, ov_o}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        runOp(OP_ADD, 64'd2, 64'd3, lat);
        runOp(OP_SUB, 64'd10, 64'd4, lat);
        nChecks++; if (lat !== 1) begin nFails++; $display("FAIL b2b_latency got %0d want 1", lat); end
        nChecks++; if (o_o !== 64'd6) begin nFails++; $display("FAIL b2b_o got %h want 6", o_o); end
    endtask

    task automatic test_busy_ignore_bin();
        start_i = 1'b1; op_i = OP_ADD; a_i = 64'd2; b_i = 64'd3;
        tick();
        op_i = OP_SUB; a_i = 64'd100; b_i = 64'd1;
        tick();
        start_i = 1'b0;
        nChecks++; if (done_o !== 1'b1) begin nFails++; $display("FAIL ign_bin_done got %b want 1", done_o); end
        nChecks++; if (o_o !== 64'd5) begin nFails++; $display("FAIL ign_bin_o got %h want 5", o_o); end
        tick();
        nChecks++; if ({busy_o, done_o} !== 2'b00) begin nFails++; $display("FAIL ign_bin_idle got %b want 00", {busy_o, done_o}); end
    endtask

`ifdef RAPTOR64_BCD_EN
    task automatic test_bcd();
        int lat;
        runOp(OP_BCD_ADD, 64'h0999, 64'h0001, lat);
        nChecks++; if (lat !== 4) begin nFails++; $display("FAIL bcd_add_latency got %0d want 4", lat); end
        nChecks++; if (o_o !== 64'h1000) begin nFails++; $display("FAIL bcd_add_o got %h want 1000", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b00) begin nFails++; $display("FAIL bcd_add_c_ov got %b want 00", {c_o, ov_o}); end
        runOp(OP_BCD_SUB, 64'h0, 64'h1, lat);
        nChecks++; if (o_o !== 64'h9999_9999_9999_9999) begin nFails++; $display("FAIL bcd_sub_o got %h want 9999999999999999", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b10) begin nFails++; $display("FAIL bcd_sub_c_ov got %b want 10", {c_o, ov_o}); end
        runOp(OP_BCD_ADD, 64'h9999_9999_9999_9999, 64'h1, lat);
        nChecks++; if (o_o !== 64'h0) begin nFails++; $display("FAIL bcd_wrap_o got %h want 0", o_o); end
        nChecks++; if (c_o !== 1'b1) begin nFails++; $display("FAIL bcd_wrap_c got %b want 1", c_o); end
        runOp(OP_BCD_SUB, 64'h1000, 64'h1, lat);
        nChecks++; if (o_o !== 64'h0999) begin nFails++; $display("FAIL bcd_sub2_o got %h want 0999", o_o); end
        nChecks++; if (c_o !== 1'b0) begin nFails++; $display("FAIL bcd_sub2_c got %b want 0", c_o); end
        runOp(OP_BCD_ADD, 64'h000C, 64'h0000, lat);
        nChecks++; if (o_o !== 64'h0012) begin nFails++; $display("FAIL bcd_nondigit_o got %h want 12", o_o); end
    endtask

    task automatic test_busy_ignore_bcd();
        start_i = 1'b1; op_i = OP_BCD_ADD; a_i = 64'h0999; b_i = 64'h0001;
        tick();
        op_i = OP_ADD; a_i = 64'h5555; b_i = 64'h5555;
        for (int k = 1; k <= 3; k++) begin
            tick();
            nChecks++; if (done_o !== 1'b0) begin nFails++; $display("FAIL ign_bcd_done cycle %0d got %b want 0", k, done_o); end
        end
        start_i = 1'b0;
        tick();
        nChecks++; if (done_o !== 1'b1) begin nFails++; $display("FAIL ign_bcd_done4 got %b want 1", done_o); end
        nChecks++; if (o_o !== 64'h1000) begin nFails++; $display("FAIL ign_bcd_o got %h want 1000", o_o); end
        tick();
        nChecks++; if ({busy_o, done_o} !== 2'b00) begin nFails++; $display("FAIL ign_bcd_idle got %b want 00", {busy_o, done_o}); end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_i = 1'b1; op_i = OP_BCD_ADD; a_i = 64'h1111; b_i = 64'h2222;
        tick();
        start_i = 1'b0;
        tick(); tick();
        rst_ni = 1'b0;
        #1;
        nChecks++; if ({busy_o, done_o} !== 2'b00) begin nFails++; $display("FAIL rstmid_busy_done got %b want 00", {busy_o, done_o}); end
        nChecks++; if ({o_o, c_o, ov_o} !== 66'h0) begin nFails++; $display("FAIL rstmid_outs got %h want 0", {o_o, c_o, ov_o}); end
        tick();
        rst_ni = 1'b1;
        tick();
        runOp(OP_ADD, 64'd2, 64'd3, lat);
        nChecks++; if (lat !== 1) begin nFails++; $display("FAIL rstmid_latency got %0d want 1", lat); end
        nChecks++; if (o_o !== 64'd5) begin nFails++; $display("FAIL rstmid_o got %h want 5", o_o); end
    endtask
`else
    task automatic test_bcd_disabled();
        int lat;
        runOp(OP_ADD, 64'd9, 64'd9, lat);
        runOp(OP_BCD_ADD, 64'h1, 64'h1, lat);
        nChecks++; if (lat !== 1) begin nFails++; $display("FAIL nobcd_latency got %0d want 1", lat); end
        nChecks++; if (o_o !== 64'h0) begin nFails++; $display("FAIL nobcd_o got %h want 0", o_o); end
        nChecks++; if ({c_o, ov_o} !== 2'b00) begin nFails++; $display("FAIL nobcd_c_ov got %b want 00", {c_o, ov_o}); end
        runOp(OP_SUBU, 64'h0, 64'h1, lat);
        runOp(OP_BCD_SUB, 64'h0, 64'h1, lat);
        nChecks++; if ({o_o, c_o, ov_o} !== 66'h0) begin nFails++; $display("FAIL nobcd_sub_outs got %h want 0", {o_o, c_o, ov_o}); end
    endtask

    task automatic test_reset_mid();
        int lat;
        runOp(OP_ADD, 64'd5, 64'd5, lat);
        start_i = 1'b1; op_i = OP_ADD; a_i = 64'd7; b_i = 64'd8;
        tick();
        start_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        nChecks++; if ({busy_o, done_o} !== 2'b00) begin nFails++; $display("FAIL rstmid_busy_done got %b want 00", {busy_o, done_o}); end
        nChecks++; if (o_o !== 64'h0) begin nFails++; $display("FAIL rstmid_o got %h want 0", o_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        nChecks++; if (done_o !== 1'b0) begin nFails++; $display("FAIL rstmid_noresume got %b want 0", done_o); end
        runOp(OP_ADD, 64'd2, 64'd3, lat);
        nChecks++; if (lat !== 1) begin nFails++; $display("FAIL rstmid_latency got %0d want 1", lat); end
        nChecks++; if (o_o !== 64'd5) begin nFails++; $display("FAIL rstmid_o2 got %h want 5", o_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_add_overflow();
        test_binary();
        test_back_to_back();
        test_busy_ignore_bin();
`ifdef RAPTOR64_BCD_EN
        test_bcd();
        test_busy_ignore_bcd();
`else
        test_bcd_disabled();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
